// File: rtl/mmio_pwm_responder.sv
// mmio_pwm_responder: memory-mapped responder for the RV32I data-memory bus.
// Decodes a 32-byte window at BASE_ADDR, services b/h/w loads and stores,
// drives four shadowed 8-bit PWM channels and keeps millisecond and
// microsecond free-running counters.
//
// Ports:
//   clk            system clock, all state on rising edge
//   reset          synchronous active-low reset
//   funct3         access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   dmem_wren      store strobe, qualified by a window hit
//   dmem_address   byte address
//   dmem_data_in   right-aligned store data
//   dmem_data_out  registered load data (0 on miss or misaligned access)
//   err_misaligned one-cycle pulse after a misaligned window access
//   led/red/green/blue  active-high PWM outputs
module mmio_pwm_responder #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int unsigned CLK_HZ    = 12_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  funct3,
    input  logic        dmem_wren,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_data_in,
    output logic [31:0] dmem_data_out,
    output logic        err_misaligned,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);

    localparam int unsigned MS_DIV_RAW = CLK_HZ / 1000;
    localparam int unsigned US_DIV_RAW = CLK_HZ / 1_000_000;
    localparam int unsigned MS_DIV     = (MS_DIV_RAW == 0) ? 1 : MS_DIV_RAW;
    localparam int unsigned US_DIV     = (US_DIV_RAW == 0) ? 1 : US_DIV_RAW;
    localparam logic [31:0] MS_LAST    = 32'(MS_DIV - 1);
    localparam logic [31:0] US_LAST    = 32'(US_DIV - 1);

    // State registers
    logic [31:0] duty_q,     duty_d;
    logic [15:0] prescale_q, prescale_d;
    logic [31:0] millis_q,   millis_d;
    logic [31:0] micros_q,   micros_d;
    logic [31:0] ms_div_q,   ms_div_d;
    logic [31:0] us_div_q,   us_div_d;
    logic [15:0] ps_cnt_q,   ps_cnt_d;
    logic [7:0]  pwm_cnt_q,  pwm_cnt_d;
    logic [31:0] shadow_q,   shadow_d;
    logic [31:0] rdata_q,    rdata_d;
    logic        err_q,      err_d;
    logic        led_q,      led_d;
    logic        red_q,      red_d;
    logic        green_q,    green_d;
    logic        blue_q,     blue_d;

    // Decode and datapath temporaries
    logic        hit;
    logic [2:0]  idx;
    logic [1:0]  lane;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        undef_op;
    logic        misaligned;
    logic        wr_en;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data;
    logic [31:0] word_rd;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_v;
    logic        prescale_wr;
    logic        tick;

    // Bus decode, load/store datapath, PWM and timers
    always_comb begin
        hit        = (dmem_address[31:5] == BASE_ADDR[31:5]);
        idx        = dmem_address[4:2];
        lane       = dmem_address[1:0];
        is_byte    = (funct3[1:0] == 2'b00);
        is_half    = (funct3[1:0] == 2'b01);
        is_word    = (funct3 == 3'b010);
        undef_op   = !(is_byte || is_half || is_word);
        // Undefined funct3 reads as an aligned word and is never flagged
        misaligned = hit && ((is_half && lane[0]) || (is_word && (lane != 2'b00)));

        // Register read mux
        word_rd = 32'h0;
        case (idx)
            3'd0:    word_rd = duty_q;
            3'd1:    word_rd = {16'h0, prescale_q};
            3'd2:    word_rd = millis_q;
            3'd3:    word_rd = micros_q;
            default: word_rd = 32'h0;
        endcase

        // Lane select and extension
        byte_v = 8'(word_rd >> {lane, 3'b000});
        half_v = lane[1] ? word_rd[31:16] : word_rd[15:0];
        if (is_byte) begin
            load_v = funct3[2] ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
        end else if (is_half) begin
            load_v = funct3[2] ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
        end else begin
            load_v = word_rd;
        end
        rdata_d = (hit && !misaligned) ? load_v : 32'h0;
        err_d   = misaligned;

        // Store lane mask and lane-replicated data
        wr_en = hit && dmem_wren && !misaligned && !undef_op;
        if (is_byte) begin
            wr_mask = 4'b0001 << lane;
            wr_data = {4{dmem_data_in[7:0]}};
        end else if (is_half) begin
            wr_mask = lane[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{dmem_data_in[15:0]}};
        end else begin
            wr_mask = 4'b1111;
            wr_data = dmem_data_in;
        end

        duty_d = duty_q;
        if (wr_en && (idx == 3'd0)) begin
            if (wr_mask[0]) duty_d[7:0]   = wr_data[7:0];
            if (wr_mask[1]) duty_d[15:8]  = wr_data[15:8];
            if (wr_mask[2]) duty_d[23:16] = wr_data[23:16];
            if (wr_mask[3]) duty_d[31:24] = wr_data[31:24];
        end

        prescale_wr = wr_en && (idx == 3'd1) && (wr_mask[1:0] != 2'b00);
        prescale_d  = prescale_q;
        if (wr_en && (idx == 3'd1)) begin
            if (wr_mask[0]) prescale_d[7:0]  = wr_data[7:0];
            if (wr_mask[1]) prescale_d[15:8] = wr_data[15:8];
        end

        // Prescaler and PWM period counter; shadow reloads at the 255->0 wrap
        tick      = (ps_cnt_q == prescale_q);
        ps_cnt_d  = (tick || prescale_wr) ? 16'h0 : ps_cnt_q + 16'd1;
        pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        shadow_d  = (tick && (pwm_cnt_q == 8'hFF)) ? duty_q : shadow_q;

        // Outputs registered from next state so they track pwm_cnt < shadow
        led_d   = (pwm_cnt_d < shadow_d[7:0]);
        red_d   = (pwm_cnt_d < shadow_d[15:8]);
        green_d = (pwm_cnt_d < shadow_d[23:16]);
        blue_d  = (pwm_cnt_d < shadow_d[31:24]);

        // Millisecond / microsecond dividers and counters
        if (ms_div_q == MS_LAST) begin
            ms_div_d = 32'h0;
            millis_d = millis_q + 32'd1;
        end else begin
            ms_div_d = ms_div_q + 32'd1;
            millis_d = millis_q;
        end
        if (us_div_q == US_LAST) begin
            us_div_d = 32'h0;
            micros_d = micros_q + 32'd1;
        end else begin
            us_div_d = us_div_q + 32'd1;
            micros_d = micros_q;
        end
    end

    // State update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            duty_q     <= 32'h0;
            prescale_q <= 16'h0;
            millis_q   <= 32'h0;
            micros_q   <= 32'h0;
            ms_div_q   <= 32'h0;
            us_div_q   <= 32'h0;
            ps_cnt_q   <= 16'h0;
            pwm_cnt_q  <= 8'h0;
            shadow_q   <= 32'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            led_q      <= 1'b0;
            red_q      <= 1'b0;
            green_q    <= 1'b0;
            blue_q     <= 1'b0;
        end else begin
            duty_q     <= duty_d;
            prescale_q <= prescale_d;
            millis_q   <= millis_d;
            micros_q   <= micros_d;
            ms_div_q   <= ms_div_d;
            us_div_q   <= us_div_d;
            ps_cnt_q   <= ps_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            shadow_q   <= shadow_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            led_q      <= led_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
        end
    end

    assign dmem_data_out  = rdata_q;
    assign err_misaligned = err_q;
    assign led            = led_q;
    assign red            = red_q;
    assign green          = green_q;
    assign blue           = blue_q;

endmodule

// File: tb/tb_mmio_pwm_responder.sv
// Testbench for mmio_pwm_responder: directed vector table, PWM and timer
// sequences, and randomized accesses checked against a byte-level model.
module tb_mmio_pwm_responder;

    localparam logic [31:0] B    = 32'hFFFF_FF00;
    localparam logic [31:0] MISS = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  funct3;
    logic        dmem_wren;
    logic [31:0] dmem_address;
    logic [31:0] dmem_data_in;
    logic [31:0] dmem_data_out;
    logic        err_misaligned;
    logic        led, red, green, blue;

    always #5 clk = ~clk;

    mmio_pwm_responder #(.BASE_ADDR(B), .CLK_HZ(12_000_000)) dut (
        .clk(clk), .reset(reset), .funct3(funct3), .dmem_wren(dmem_wren),
        .dmem_address(dmem_address), .dmem_data_in(dmem_data_in),
        .dmem_data_out(dmem_data_out), .err_misaligned(err_misaligned),
        .led(led), .red(red), .green(green), .blue(blue)
    );

    // Clock edges seen with reset released, zeroed by reset
    int unsigned live = 0;
    always @(posedge clk) live <= reset ? live + 1 : 0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  f3;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [28];

    // Model state: DUTY bytes 0..3, PRESCALE bytes 4..5
    logic [7:0] mb [0:5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic access(input logic [2:0] f3, input logic we, input logic [31:0] a,
                          input logic [31:0] d);
        funct3 = f3; dmem_wren = we; dmem_address = a; dmem_data_in = d;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) access(3'b010, 1'b0, MISS, 32'h0);
    endtask

    function automatic logic [7:0] mbyte(input int unsigned off, input int unsigned lv);
        logic [31:0] t;
        if (off < 6) return mb[off];
        if (off >= 8 && off < 12) begin
            t = 32'((lv - 1) / 12000);
            return 8'(t >> (8 * (off - 8)));
        end
        if (off >= 12 && off < 16) begin
            t = 32'((lv - 1) / 12);
            return 8'(t >> (8 * (off - 12)));
        end
        return 8'h0;
    endfunction

    // Byte-addressed view: n-byte little-endian access at the window offset
    task automatic model_access(input logic [2:0] f3, input logic we, input logic [31:0] a,
                                input logic [31:0] d, input int unsigned lv,
                                output logic [31:0] erd, output logic eerr);
        bit hit, mis, undef;
        int unsigned n, off, start;
        logic [31:0] v;
        hit   = (a[31:5] == B[31:5]);
        undef = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        n     = undef ? 4 : (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off   = 32'(a[4:0]);
        mis   = hit && !undef && ((off % n) != 0);
        start = undef ? off - (off % 4) : off;
        v = 32'h0;
        for (int i = 0; i < int'(n); i++) v = v | (32'(mbyte(start + i, lv)) << (8 * i));
        if (!undef && !f3[2]) begin
            if (n == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (n == 2 && v[15]) v = v | 32'hFFFF_0000;
        end
        erd  = (hit && !mis) ? v : 32'h0;
        eerr = mis;
        if (hit && we && !mis && !undef)
            for (int i = 0; i < int'(n); i++)
                if (start + i < 6) mb[start + i] = 8'(d >> (8 * i));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, c_led, c_red, c_green, c_blue;
        logic [31:0] erd, a, d;
        logic eerr, we;
        logic [2:0] f3;
        logic [2:0] f3_set [8];

        vecs[0]  = '{3'b010, 1'b1, B + 32'h00, 32'h80FF7F01, 32'h00000000, 1'b0};
        vecs[1]  = '{3'b010, 1'b0, B + 32'h00, 32'h0,        32'h80FF7F01, 1'b0};
        vecs[2]  = '{3'b000, 1'b0, B + 32'h03, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[3]  = '{3'b100, 1'b0, B + 32'h03, 32'h0,        32'h00000080, 1'b0};
        vecs[4]  = '{3'b001, 1'b0, B + 32'h02, 32'h0,        32'hFFFF80FF, 1'b0};
        vecs[5]  = '{3'b000, 1'b1, B + 32'h01, 32'h00000055, 32'h0000007F, 1'b0};
        vecs[6]  = '{3'b010, 1'b0, B + 32'h00, 32'h0,        32'h80FF5501, 1'b0};
        vecs[7]  = '{3'b010, 1'b1, B + 32'h06, 32'h12345678, 32'h00000000, 1'b1};
        vecs[8]  = '{3'b010, 1'b0, B + 32'h00, 32'h0,        32'h80FF5501, 1'b0};
        vecs[9]  = '{3'b010, 1'b0, B + 32'h04, 32'h0,        32'h00000000, 1'b0};
        vecs[10] = '{3'b001, 1'b1, B + 32'h04, 32'hABCD1234, 32'h00000000, 1'b0};
        vecs[11] = '{3'b101, 1'b0, B + 32'h04, 32'h0,        32'h00001234, 1'b0};
        vecs[12] = '{3'b010, 1'b1, B + 32'h04, 32'hFFFFFFFF, 32'h00001234, 1'b0};
        vecs[13] = '{3'b010, 1'b0, B + 32'h04, 32'h0,        32'h0000FFFF, 1'b0};
        vecs[14] = '{3'b001, 1'b0, B + 32'h05, 32'h0,        32'h00000000, 1'b1};
        vecs[15] = '{3'b101, 1'b0, B + 32'h06, 32'h0,        32'h00000000, 1'b0};
        vecs[16] = '{3'b010, 1'b1, B + 32'h10, 32'h11111111, 32'h00000000, 1'b0};
        vecs[17] = '{3'b010, 1'b0, B + 32'h1C, 32'h0,        32'h00000000, 1'b0};
        vecs[18] = '{3'b010, 1'b1, 32'hFFFFFEFC, 32'h0,      32'h00000000, 1'b0};
        vecs[19] = '{3'b010, 1'b0, B + 32'h00, 32'h0,        32'h80FF5501, 1'b0};
        vecs[20] = '{3'b011, 1'b1, B + 32'h00, 32'h0,        32'h80FF5501, 1'b0};
        vecs[21] = '{3'b010, 1'b0, B + 32'h00, 32'h0,        32'h80FF5501, 1'b0};
        vecs[22] = '{3'b010, 1'b1, B + 32'h04, 32'h0,        32'h0000FFFF, 1'b0};
        vecs[23] = '{3'b010, 1'b0, B + 32'h04, 32'h0,        32'h00000000, 1'b0};
        vecs[24] = '{3'b101, 1'b0, B + 32'h02, 32'h0,        32'h000080FF, 1'b0};
        vecs[25] = '{3'b001, 1'b1, B + 32'h02, 32'hFFFF1234, 32'hFFFF80FF, 1'b0};
        vecs[26] = '{3'b010, 1'b0, B + 32'h00, 32'h0,        32'h12345501, 1'b0};
        vecs[27] = '{3'b000, 1'b0, B + 32'h02, 32'h0,        32'h00000034, 1'b0};

        // Reset held with a store pending
        reset = 1'b0;
        funct3 = 3'b010; dmem_wren = 1'b1; dmem_address = B; dmem_data_in = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_rdata", dmem_data_out, 32'h0);
            chk("rst_err", 32'(err_misaligned), 32'h0);
            chk("rst_pwm", {28'h0, led, red, green, blue}, 32'h0);
        end
        reset = 1'b1;
        access(3'b010, 1'b0, B, 32'h0);
        chk("rst_duty_read", dmem_data_out, 32'h0);

        // Directed vector table
        for (int i = 0; i < 28; i++) begin
            access(vecs[i].f3, vecs[i].we, vecs[i].addr, vecs[i].wd);
            chk($sformatf("vec%0d_rdata", i), dmem_data_out, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(err_misaligned), 32'(vecs[i].exp_err));
        end

        // PWM duty ratios with PRESCALE = 0
        access(3'b010, 1'b1, B, 32'h00FF4000);
        idle(600);
        c_led = 0; c_red = 0; c_green = 0; c_blue = 0;
        for (int i = 0; i < 256; i++) begin
            idle(1);
            c_led += int'(led); c_red += int'(red); c_green += int'(green); c_blue += int'(blue);
        end
        chk("pwm_led_count", 32'(c_led), 32'd0);
        chk("pwm_red_count", 32'(c_red), 32'd64);
        chk("pwm_green_count", 32'(c_green), 32'd255);
        chk("pwm_blue_count", 32'(c_blue), 32'd0);

        // Mid-period DUTY change waits for the wrap
        k = 0;
        while (red !== 1'b0 && k < 600) begin idle(1); k++; end
        while (red !== 1'b1 && k < 600) begin idle(1); k++; end
        chk("pwm_sync_timeout", 32'(k < 600), 32'd1);
        idle(100);
        access(3'b010, 1'b1, B, 32'h00000080);
        c_led = 0; c_green = 0;
        for (int i = 0; i < 154; i++) begin
            idle(1);
            c_led += int'(led); c_green += int'(green);
        end
        chk("pwm_no_glitch_led", 32'(c_led), 32'd0);
        chk("pwm_old_green", 32'(c_green), 32'd153);
        idle(1);
        chk("pwm_after_wrap", {29'h0, led, red, green}, 32'b100);

        // Timers after a fresh reset
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) mb[i] = 8'h0;
        k = 0;
        while (live < 35999 && k < 40000) begin idle(1); k++; end
        chk("timer_wait", live, 32'd35999);
        access(3'b010, 1'b0, B + 32'h08, 32'h0);
        chk("millis_pre_inc", dmem_data_out, 32'd2);
        access(3'b010, 1'b0, B + 32'h08, 32'h0);
        chk("millis_3", dmem_data_out, 32'd3);
        access(3'b010, 1'b0, B + 32'h0C, 32'h0);
        chk("micros_3000", dmem_data_out, 32'd3000);
        access(3'b010, 1'b1, B + 32'h08, 32'h0);
        chk("millis_write_rd", dmem_data_out, 32'd3);
        access(3'b010, 1'b0, B + 32'h08, 32'h0);
        chk("millis_unchanged", dmem_data_out, 32'd3);

        // Randomized accesses against the byte model
        f3_set = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 600; i++) begin
            f3 = f3_set[$urandom_range(0, 7)];
            we = 1'($urandom_range(0, 1));
            d  = $urandom;
            if ($urandom_range(0, 3) != 0) a = B | 32'($urandom_range(0, 31));
            else a = $urandom;
            if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) a[1:0] = 2'b00;
            access(f3, we, a, d);
            model_access(f3, we, a, d, live, erd, eerr);
            chk($sformatf("rand%0d_rdata f3=%b a=%h", i, f3, a), dmem_data_out, erd);
            chk($sformatf("rand%0d_err", i), 32'(err_misaligned), 32'(eerr));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
